// File: rtl/dds_phase_accum.sv
// dds_phase_accum: modulo-PERIOD phase accumulator that addresses the DDS sine lookup.
// Optional macro DDS_PHASE_OFFSET_EN adds a per-run phase_offset input applied to the address.
module dds_phase_accum #(
    parameter int unsigned PERIOD = 252,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tw_valid,
    output logic                tw_ready,
    input  logic [8+FRAC_W-1:0] tw_data,
    output logic                tw_err,
    input  logic                start,
    input  logic                stop,
    input  logic [CNT_W-1:0]    burst_len,
`ifdef DDS_PHASE_OFFSET_EN
    input  logic [7:0]          phase_offset,
`endif
    output logic [7:0]          address,
    output logic                addr_valid,
    output logic                busy,
    output logic                done
);
    localparam int unsigned W      = 8 + FRAC_W;
    localparam int unsigned MOD_I  = PERIOD << FRAC_W;
    localparam logic [W:0]  ACC_MOD  = MOD_I[W:0];
    localparam logic [8:0]  PERIOD_9 = PERIOD[8:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_next;
    logic [W-1:0]     acc, tw_cur, tw_pend, acc_next;
    logic             pend;
    logic [CNT_W-1:0] cnt, len;
    logic [W:0]       sum, diff;
    logic             wrap, tw_offer, tw_bad, tw_take, burst_end, leaving;

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, tw_cur};
        diff       = sum - ACC_MOD;
        wrap       = (sum >= ACC_MOD);
        acc_next   = wrap ? diff[W-1:0] : sum[W-1:0];
        tw_ready   = (state == IDLE) || !pend;
        tw_offer   = tw_valid && tw_ready;
        tw_bad     = ({1'b0, tw_data[W-1:FRAC_W]} >= PERIOD_9);
        tw_take    = tw_offer && !tw_bad;
        burst_end  = (len != '0) && (cnt == len - CNT_ONE);
        state_next = state;
        case (state)
            IDLE: if (start && !stop) state_next = RUN;
            RUN:  if (stop || burst_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        leaving = (state == RUN) && (state_next == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

`ifdef DDS_PHASE_OFFSET_EN
    logic [7:0] offset;
    logic [8:0] addr_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            tw_cur  <= '0;
            tw_pend <= '0;
            pend    <= 1'b0;
            cnt     <= '0;
            len     <= '0;
            tw_err  <= 1'b0;
            done    <= 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
            offset  <= '0;
`endif
        end else begin
            tw_err <= tw_offer && tw_bad;
            done   <= leaving && !stop;
            if (state == IDLE) begin
                if (tw_take) tw_cur <= tw_data;
                if (state_next == RUN) begin
                    acc <= '0;
                    cnt <= '0;
                    len <= burst_len;
`ifdef DDS_PHASE_OFFSET_EN
                    offset <= phase_offset;
`endif
                end
            end else if (leaving) begin
                // acc cleared on exit so the address reads 0 for the whole IDLE stay;
                // a word arriving on the exit edge supersedes an older pending one
                acc  <= '0;
                cnt  <= '0;
                pend <= 1'b0;
`ifdef DDS_PHASE_OFFSET_EN
                offset <= '0;
`endif
                if (tw_take)   tw_cur <= tw_data;
                else if (pend) tw_cur <= tw_pend;
            end else begin
                acc <= acc_next;
                cnt <= cnt + CNT_ONE;
                if (wrap && pend) begin
                    tw_cur <= tw_pend;
                    pend   <= 1'b0;
                end
                if (tw_take) begin
                    tw_pend <= tw_data;
                    pend    <= 1'b1;
                end
            end
        end
    end

`ifdef DDS_PHASE_OFFSET_EN
    always_comb begin
        addr_sum = {1'b0, acc[W-1:FRAC_W]} + {1'b0, offset};
        if (addr_sum >= PERIOD_9) addr_sum = addr_sum - PERIOD_9;
        address = (state == RUN) ? addr_sum[7:0] : '0;
    end
`else
    assign address = acc[W-1:FRAC_W];
`endif

    assign addr_valid = (state == RUN);
    assign busy       = (state == RUN);

endmodule

// File: tb/tb_dds_phase_accum.sv
// Self-checking bench for dds_phase_accum: directed steps plus random bursts against a closed-form phase model.
module tb_dds_phase_accum;
    localparam int unsigned PERIOD = 252;
    localparam int unsigned FRAC_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned MOD    = PERIOD << FRAC_W;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tw_valid = 1'b0;
    logic        tw_ready;
    logic [15:0] tw_data = '0;
    logic        tw_err;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] burst_len = '0;
    logic [7:0]  address;
    logic        addr_valid;
    logic        busy;
    logic        done;
`ifdef DDS_PHASE_OFFSET_EN
    logic [7:0]  phase_offset = '0;
`endif

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    dds_phase_accum #(.PERIOD(PERIOD), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .tw_valid(tw_valid),
        .tw_ready(tw_ready),
        .tw_data(tw_data),
        .tw_err(tw_err),
        .start(start),
        .stop(stop),
        .burst_len(burst_len),
`ifdef DDS_PHASE_OFFSET_EN
        .phase_offset(phase_offset),
`endif
        .address(address),
        .addr_valid(addr_valid),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required summary");
        $fatal(1);
    end

    // Sample k of a run at constant step tw sits at phase k*tw around the period circle.
    function automatic int unsigned model_addr(input int unsigned k, input int unsigned tw);
        return ((k * tw) % MOD) >> FRAC_W;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [15:0] word, input logic bad);
        tw_data  = word;
        tw_valid = 1'b1;
        tick();
        tw_valid = 1'b0;
        check("tw_err", 32'(tw_err), 32'(bad));
    endtask

    task automatic begin_run(input logic [15:0] len);
        burst_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_on_start", 32'(busy), 32'd1);
    endtask

    task automatic run_check(input string tag, input int unsigned tw,
                             input int unsigned k0, input int unsigned k1);
        for (int unsigned k = k0; k <= k1; k++) begin
            check(tag, 32'(address), model_addr(k, tw));
            check("addr_valid", 32'(addr_valid), 32'd1);
            tick();
        end
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_valid", 32'(addr_valid), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        check("stop_addr", 32'(address), 32'd0);
    endtask

    initial begin
        int unsigned tw, len;

        tick();
        tick();
        check("rst_addr", 32'(address), 32'd0);
        check("rst_valid", 32'(addr_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(tw_err), 32'd0);
        check("rst_ready", 32'(tw_ready), 32'd1);
        rst = 1'b0;
        tick();

        // step 1.0, full period plus wrap
        offer(16'h0100, 1'b0);
        begin_run(16'd0);
        run_check("unit_step", 32'h0100, 0, 253);
        halt();

        // step 2.5, fractional carry across the wrap
        offer(16'h0280, 1'b0);
        begin_run(16'd0);
        run_check("step_2_5", 32'h0280, 0, 99);
        check("s100", 32'(address), 32'd250);
        tick();
        check("s101", 32'(address), 32'd0);
        tick();
        check("s102", 32'(address), 32'd3);
        halt();

        // out-of-range word rejected, old step retained
        offer(16'hFC00, 1'b1);
        tick();
        check("err_pulse_end", 32'(tw_err), 32'd0);
        begin_run(16'd0);
        run_check("after_reject", 32'h0280, 0, 4);
        halt();
        offer(16'hFB00, 1'b0);
        begin_run(16'd0);
        run_check("step_fb", 32'hFB00, 0, 5);
        halt();

        // phase-continuous change at the period boundary
        offer(16'h0100, 1'b0);
        begin_run(16'd0);
        run_check("pre_change", 32'h0100, 0, 9);
        check("ready_before", 32'(tw_ready), 32'd1);
        tw_data  = 16'h0400;
        tw_valid = 1'b1;
        tick();
        tw_valid = 1'b0;
        for (int unsigned k = 11; k <= 251; k++) begin
            check("pend_addr", 32'(address), 32'(k));
            check("pend_ready", 32'(tw_ready), 32'd0);
            tick();
        end
        for (int unsigned j = 0; j <= 5; j++) begin
            check("new_step", 32'(address), model_addr(j, 32'h0400));
            check("ready_after", 32'(tw_ready), 32'd1);
            tick();
        end
        halt();

        // burst of 5
        offer(16'h0100, 1'b0);
        begin_run(16'd5);
        for (int unsigned k = 0; k < 5; k++) begin
            check("burst_addr", 32'(address), 32'(k));
            check("burst_done_low", 32'(done), 32'd0);
            check("burst_busy", 32'(busy), 32'd1);
            tick();
        end
        check("burst_done", 32'(done), 32'd1);
        check("burst_end_busy", 32'(busy), 32'd0);
        check("burst_end_valid", 32'(addr_valid), 32'd0);
        check("burst_end_addr", 32'(address), 32'd0);
        tick();
        check("done_one_cycle", 32'(done), 32'd0);

        // stop at address 37
        begin_run(16'd0);
        run_check("to_37", 32'h0100, 0, 36);
        check("at_37", 32'(address), 32'd37);
        halt();
        check("stop_busy", 32'(busy), 32'd0);

        // reset mid-run with a pending word: pending discarded, step back to 0
        begin_run(16'd0);
        run_check("to_15", 32'h0100, 0, 14);
        tw_data  = 16'h0300;
        tw_valid = 1'b1;
        tick();
        tw_valid = 1'b0;
        run_check("to_20", 32'h0100, 16, 19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_addr", 32'(address), 32'd0);
        check("mrst_valid", 32'(addr_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_ready", 32'(tw_ready), 32'd1);
        begin_run(16'd0);
        run_check("zero_step", 32'h0000, 0, 3);
        halt();

        // start with stop in IDLE: stop wins
        offer(16'h0100, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", 32'(busy), 32'd0);
        check("ss_valid", 32'(addr_valid), 32'd0);
        tick();
        check("ss_addr", 32'(address), 32'd0);

        // pending word applied on entry to IDLE
        begin_run(16'd0);
        run_check("pre_idle_pend", 32'h0100, 0, 4);
        tw_data  = 16'h0200;
        tw_valid = 1'b1;
        tick();
        tw_valid = 1'b0;
        run_check("pend_held", 32'h0100, 6, 7);
        halt();
        begin_run(16'd0);
        run_check("pend_on_idle", 32'h0200, 0, 5);
        halt();

        // randomized bursts, each preceded by a rejected word
        for (int r = 0; r < 6; r++) begin
            offer(16'($urandom_range(65535, MOD)), 1'b1);
            tw  = $urandom_range(MOD - 1, 0);
            len = $urandom_range(40, 1);
            offer(16'(tw), 1'b0);
            begin_run(16'(len));
            run_check("rand_burst", tw, 0, len - 1);
            check("rand_done", 32'(done), 32'd1);
            check("rand_valid_off", 32'(addr_valid), 32'd0);
            tick();
            check("rand_done_off", 32'(done), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
